// File: rtl/seg7.sv
// Registered seven-segment decoder: one 4-bit digit in, seven segment lines out.
// Output register clears to blank asynchronously; decode has one cycle of latency.
module seg7 #(
    parameter bit HEX_EN     = 1'b1,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] bcd,
    output logic [6:0] leds
);

    localparam logic [6:0] BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [6:0] pat_n;  // active-low pattern, g..a
    logic [6:0] pat;

    always_comb begin
        pat_n = 7'h7F;
        case (bcd)
            4'h0: pat_n = 7'h40;
            4'h1: pat_n = 7'h79;
            4'h2: pat_n = 7'h24;
            4'h3: pat_n = 7'h30;
            4'h4: pat_n = 7'h19;
            4'h5: pat_n = 7'h12;
            4'h6: pat_n = 7'h02;
            4'h7: pat_n = 7'h78;
            4'h8: pat_n = 7'h00;
            4'h9: pat_n = 7'h10;
            4'hA: pat_n = HEX_EN ? 7'h08 : 7'h7F;
            4'hB: pat_n = HEX_EN ? 7'h03 : 7'h7F;
            4'hC: pat_n = HEX_EN ? 7'h46 : 7'h7F;
            4'hD: pat_n = HEX_EN ? 7'h21 : 7'h7F;
            4'hE: pat_n = HEX_EN ? 7'h06 : 7'h7F;
            4'hF: pat_n = HEX_EN ? 7'h0E : 7'h7F;
            default: pat_n = 7'h7F;
        endcase
        pat = ACTIVE_LOW ? pat_n : ~pat_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) leds <= BLANK;
        else       leds <= pat;
    end

endmodule

// File: tb/tb_seg7.sv
// Randomized check of seg7 in several parameterizations against a segment-name reference model.
module tb_seg7;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] sw = 8'h00;
    logic [6:0] leds_def, leds_nohex, leds_ahi, leds_hi;
    int         total = 0;
    int         bad = 0;
    bit         in_rst = 1'b0;
    logic [7:0] sw_q = 8'h00;

    always #5 clk = ~clk;

    seg7 u_def   (.clk(clk), .reset(reset), .bcd(sw[3:0]), .leds(leds_def));
    seg7 #(.HEX_EN(1'b0)) u_nohex (.clk(clk), .reset(reset), .bcd(sw[3:0]), .leds(leds_nohex));
    seg7 #(.ACTIVE_LOW(1'b0)) u_ahi (.clk(clk), .reset(reset), .bcd(sw[3:0]), .leds(leds_ahi));
    seg7 u_hi    (.clk(clk), .reset(reset), .bcd(sw[7:4]), .leds(leds_hi));

    // lit segments per code, named a..g
    string segs [0:15] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                           "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [6:0] model(int d, bit hex, bit al, bit blank);
        logic [6:0] lit = 7'h00;
        if (!blank && (d < 10 || hex))
            for (int i = 0; i < segs[d].len(); i++) lit[int'(segs[d][i]) - 97] = 1'b1;
        return al ? ~lit : lit;
    endfunction

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".def"},   leds_def,   model(int'(sw_q[3:0]), 1, 1, in_rst));
        chk({tag, ".nohex"}, leds_nohex, model(int'(sw_q[3:0]), 0, 1, in_rst));
        chk({tag, ".ahi"},   leds_ahi,   model(int'(sw_q[3:0]), 1, 0, in_rst));
        chk({tag, ".hi"},    leds_hi,    model(int'(sw_q[7:4]), 1, 1, in_rst));
    endtask

    // drive at negedge, clock it in, sample 1 time unit later
    task automatic step(input logic [7:0] v, input string tag);
        @(negedge clk);
        sw = v;
        @(posedge clk);
        sw_q = v;
        in_rst = 1'b0;
        #1;
        check_all(tag);
    endtask

    initial begin
        // reset with no clock edge
        @(negedge clk);
        sw = 8'h88;
        #1 reset = 1'b1;
        #1;
        in_rst = 1'b1;
        check_all("rst");
        chk("rst.const", leds_def, 7'h7F);
        chk("rst.ahi.const", leds_ahi, 7'h00);
        @(negedge clk);
        reset = 1'b0;
        #1 check_all("rst.hold");
        step(8'h88, "rel");
        chk("rel.const", leds_def, 7'h00);

        // full pair sweep
        for (int v = 0; v < 256; v++) begin
            step(v[7:0], $sformatf("sweep%0d", v));
            if (v == 0)     chk("ep0",  leds_def, 7'h40);
            if (v == 9)     chk("ep9",  leds_def, 7'h10);
            if (v == 15)    chk("ep15", leds_def, 7'h0E);
            if (v == 3)     chk("nohex3", leds_nohex, 7'h30);
            if (v == 12)    chk("nohex12", leds_nohex, 7'h7F);
            if (v == 1)     chk("ahi1", leds_ahi, 7'h06);
            if (v == 8'hA5) begin
                chk("pairA5.lo", leds_def, 7'h12);
                chk("pairA5.hi", leds_hi, 7'h08);
            end
        end

        // reset pulse between edges while bcd=7
        step(8'h77, "mid.pre");
        #2 reset = 1'b1;
        #1 in_rst = 1'b1;
        check_all("mid.rst");
        reset = 1'b0;
        #1 check_all("mid.hold");
        step(8'h77, "mid.rel");
        chk("mid.const", leds_def, 7'h78);

        // random values every cycle, with occasional mid-cycle reset pulses
        for (int n = 0; n < 400; n++) begin
            step(8'($urandom_range(0, 255)), $sformatf("rnd%0d", n));
            if ($urandom_range(0, 9) == 0) begin
                #1 reset = 1'b1;
                #1 in_rst = 1'b1;
                check_all($sformatf("rnd%0d.rst", n));
                reset = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
